and_check_seq: RTL

Self-checking stimulus sequencer for the 2-input AND gate datapath. It drives a shared operand pair (a_o, b_o) into both the gate under test and the behavioural reference gate, waits a programmable settle time, and compares the two results. It keeps pass and fail counts and reports completion. This moves the comparison done by the simulation-only bench into synthesizable logic, so the check can run on silicon or an FPGA as well as in simulation.

---
 rtl/and_check_seq_if.sv | 28 ++
 rtl/and_check_seq.sv | 124 ++++++++++++
 2 files changed

// File: rtl/and_check_seq_if.sv
// Operand/result/status bundle between the AND-gate check sequencer and the gates it exercises.
// master = sequencer side; slave = gates plus whoever starts runs and reads status.
interface and_check_seq_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             y_dut;
  logic             y_ref;
  logic             a_o;
  logic             b_o;
  logic             busy;
  logic             done;
  logic             pass;
  logic             mismatch;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic [CNT_W-1:0] first_fail_idx;

  modport master (
    input  start, y_dut, y_ref,
    output a_o, b_o, busy, done, pass, mismatch, pass_cnt, fail_cnt, first_fail_idx
  );

  modport slave (
    output start, y_dut, y_ref,
    input  a_o, b_o, busy, done, pass, mismatch, pass_cnt, fail_cnt, first_fail_idx
  );
endinterface

// File: rtl/and_check_seq.sv
// LFSR-driven AND-gate check sequencer: NUM_VECTORS*(SETTLE+2) cycles per run, all outputs registered.
// No backpressure: start is taken only in IDLE and ignored while busy.
module and_check_seq #(
  parameter int         NUM_VECTORS = 4,
  parameter int         SETTLE      = 2,
  parameter logic [7:0] SEED        = 8'hA5,
  parameter int         CNT_W       = 8
) (
  input logic            clk,
  input logic            rst,
  and_check_seq_if.master bus
);

  localparam int WAIT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [WAIT_W-1:0] SETTLE_V = WAIT_W'(SETTLE);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NUM_VECTORS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CHECK
  } state_t;

  state_t            state_q;
  logic [7:0]        lfsr_q;
  logic [7:0]        lfsr_d;
  logic [WAIT_W-1:0] wait_q;
  logic [CNT_W-1:0]  idx_q;
  logic [CNT_W-1:0]  pass_cnt_q;
  logic [CNT_W-1:0]  fail_cnt_q;
  logic [CNT_W-1:0]  first_fail_q;
  logic              a_q;
  logic              b_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic              mismatch_q;
  logic              match;

  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign match  = (bus.y_dut == bus.y_ref);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      lfsr_q       <= SEED;
      wait_q       <= '0;
      idx_q        <= '0;
      pass_cnt_q   <= '0;
      fail_cnt_q   <= '0;
      first_fail_q <= '0;
      a_q          <= 1'b0;
      b_q          <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      mismatch_q   <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            lfsr_q       <= SEED;
            idx_q        <= '0;
            pass_cnt_q   <= '0;
            fail_cnt_q   <= '0;
            first_fail_q <= '0;
            pass_q       <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= S_APPLY;
          end
        end
        S_APPLY: begin
          a_q     <= lfsr_q[5];
          b_q     <= lfsr_q[0];
          lfsr_q  <= lfsr_d;
          wait_q  <= SETTLE_V;
          state_q <= S_SETTLE;
        end
        S_SETTLE: begin
          // Leaving when the counter is at 1 gives exactly SETTLE cycles here.
          wait_q <= wait_q - WAIT_W'(1);
          if (wait_q == WAIT_W'(1)) begin
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (match) begin
            pass_cnt_q <= pass_cnt_q + CNT_W'(1);
          end else begin
            fail_cnt_q <= fail_cnt_q + CNT_W'(1);
            mismatch_q <= 1'b1;
            if (fail_cnt_q == '0) begin
              first_fail_q <= idx_q;
            end
          end
          if (idx_q == LAST_IDX) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= match && (fail_cnt_q == '0);
            state_q <= S_IDLE;
          end else begin
            idx_q   <= idx_q + CNT_W'(1);
            state_q <= S_APPLY;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.a_o            = a_q;
  assign bus.b_o            = b_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.mismatch       = mismatch_q;
  assign bus.pass_cnt       = pass_cnt_q;
  assign bus.fail_cnt       = fail_cnt_q;
  assign bus.first_fail_idx = first_fail_q;

endmodule
